// File: rtl/simeck_engine.sv
// rtl/simeck_engine.sv - Iterative Simeck32/48/64 engine with a one-time expanded round-key store
module simeck_engine #(
  parameter int WORD_W = 16,
  parameter int ROUNDS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [4*WORD_W-1:0] key,
  input  logic                blk_in_valid,
  output logic                blk_in_ready,
  input  logic [2*WORD_W-1:0] blk_in,
  input  logic                mode,
  output logic                blk_out_valid,
  input  logic                blk_out_ready,
  output logic [2*WORD_W-1:0] blk_out,
  output logic                key_loaded,
  output logic                busy
);
  localparam int CW = $clog2(ROUNDS);
  localparam logic [WORD_W-1:0] KC = {{(WORD_W-2){1'b1}}, 2'b00};
  localparam logic [CW-1:0] LAST = CW'(ROUNDS-1);
  localparam bit Z1 = (WORD_W == 32);

  generate
    if (!((WORD_W == 16 && ROUNDS == 32) || (WORD_W == 24 && ROUNDS == 36) ||
          (WORD_W == 32 && ROUNDS == 44))) begin : g_bad_cfg
      $error("simeck_engine: unsupported WORD_W/ROUNDS pairing");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, EXPAND, READY, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [5:0]        lfsr;
  logic [WORD_W-1:0] kw, t0, t1, t2, l, r;
  logic              dec, in_rdy;
  logic [WORD_W-1:0] rk [ROUNDS];

  function automatic logic [WORD_W-1:0] f(input logic [WORD_W-1:0] x);
    return (x & {x[WORD_W-6:0], x[WORD_W-1:WORD_W-5]}) ^ {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction

  logic [CW-1:0]     rk_idx;
  logic [WORD_W-1:0] rk_cur, t_new, l_nxt, r_nxt;
  logic [5:0]        lfsr_nxt;

  // lfsr[0] is the current z bit; the window shifts down with feedback into the top
  always_comb begin
    rk_idx   = dec ? LAST - cnt : cnt;
    rk_cur   = rk[rk_idx];
    t_new    = kw ^ f(t0) ^ KC ^ {{(WORD_W-1){1'b0}}, lfsr[0]};
    lfsr_nxt = Z1 ? {lfsr[1] ^ lfsr[0], lfsr[5:1]} : {1'b0, lfsr[2] ^ lfsr[0], lfsr[4:1]};
    if (dec) begin
      l_nxt = r;
      r_nxt = l ^ f(r) ^ rk_cur;
    end else begin
      l_nxt = r ^ f(l) ^ rk_cur;
      r_nxt = l;
    end
  end

  assign blk_in_ready = in_rdy & ~key_valid;

  // Store is deliberately left out of reset; key_loaded guards its use
  always_ff @(posedge clk) begin
    if (state == EXPAND) rk[cnt] <= kw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lfsr          <= '0;
      kw            <= '0;
      t0            <= '0;
      t1            <= '0;
      t2            <= '0;
      l             <= '0;
      r             <= '0;
      dec           <= 1'b0;
      in_rdy        <= 1'b0;
      key_ready     <= 1'b0;
      key_loaded    <= 1'b0;
      blk_out_valid <= 1'b0;
      blk_out       <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          key_ready <= 1'b1;
          if (key_valid && key_ready) begin
            {t2, t1, t0, kw} <= key;
            lfsr       <= Z1 ? 6'b111111 : 6'b011111;
            cnt        <= '0;
            key_loaded <= 1'b0;
            key_ready  <= 1'b0;
            in_rdy     <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end else if (blk_in_valid && blk_in_ready) begin
            {l, r}    <= blk_in;
            dec       <= mode;
            cnt       <= '0;
            key_ready <= 1'b0;
            in_rdy    <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        EXPAND: begin
          {kw, t0, t1, t2} <= {t0, t1, t2, t_new};
          lfsr <= lfsr_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt        <= '0;
            key_loaded <= 1'b1;
            key_ready  <= 1'b1;
            in_rdy     <= 1'b1;
            busy       <= 1'b0;
            state      <= READY;
          end
        end
        RUN: begin
          l   <= l_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt           <= '0;
            blk_out       <= {l_nxt, r_nxt};
            blk_out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (blk_out_ready) begin
            blk_out_valid <= 1'b0;
            key_ready     <= 1'b1;
            in_rdy        <= 1'b1;
            busy          <= 1'b0;
            state         <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simeck_engine.sv
// tb/tb_simeck_engine.sv - Directed checks of simeck_engine at WORD_W 16 and 32
module tb_simeck_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  localparam logic [63:0]  K16 = 64'h1918111009080100;
  localparam logic [31:0]  P16 = 32'h65656877;
  localparam logic [31:0]  C16 = 32'h770d2c76;
  localparam logic [127:0] K32 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  P32 = 64'h656b696c_20646e75;
  localparam logic [63:0]  C32 = 64'h45ce6902_5f7ab7ed;

  logic        a_key_valid, a_key_ready, a_blk_in_valid, a_blk_in_ready, a_mode;
  logic        a_blk_out_valid, a_blk_out_ready, a_key_loaded, a_busy;
  logic [63:0] a_key;
  logic [31:0] a_blk_in, a_blk_out;

  logic         b_key_valid, b_key_ready, b_blk_in_valid, b_blk_in_ready, b_mode;
  logic         b_blk_out_valid, b_blk_out_ready, b_key_loaded, b_busy;
  logic [127:0] b_key;
  logic [63:0]  b_blk_in, b_blk_out;

  simeck_engine #(.WORD_W(16), .ROUNDS(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key),
    .blk_in_valid(a_blk_in_valid), .blk_in_ready(a_blk_in_ready), .blk_in(a_blk_in), .mode(a_mode),
    .blk_out_valid(a_blk_out_valid), .blk_out_ready(a_blk_out_ready), .blk_out(a_blk_out),
    .key_loaded(a_key_loaded), .busy(a_busy)
  );

  simeck_engine #(.WORD_W(32), .ROUNDS(44)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key),
    .blk_in_valid(b_blk_in_valid), .blk_in_ready(b_blk_in_ready), .blk_in(b_blk_in), .mode(b_mode),
    .blk_out_valid(b_blk_out_valid), .blk_out_ready(b_blk_out_ready), .blk_out(b_blk_out),
    .key_loaded(b_key_loaded), .busy(b_busy)
  );

  task automatic a_load_key(input logic [63:0] k, output bit ok);
    int n;
    n = 0;
    while (!a_key_ready && n < 100) begin @(negedge clk); n++; end
    a_key = k; a_key_valid = 1'b1;
    @(negedge clk);
    a_key_valid = 1'b0;
    n = 0;
    while (!a_key_loaded && n < 100) begin @(negedge clk); n++; end
    ok = a_key_loaded;
  endtask

  task automatic a_run(input logic [31:0] d, input logic m, output logic [31:0] res,
                       output int lat, output bit busy_ok);
    int n;
    n = 0;
    busy_ok = 1'b1;
    while (!a_blk_in_ready && n < 100) begin @(negedge clk); n++; end
    a_blk_in = d; a_mode = m; a_blk_in_valid = 1'b1;
    @(negedge clk);
    a_blk_in_valid = 1'b0;
    lat = 0;
    while (!a_blk_out_valid && lat < 100) begin busy_ok = busy_ok & a_busy; @(negedge clk); lat++; end
    res = a_blk_out;
  endtask

  task automatic a_drain();
    a_blk_out_ready = 1'b1;
    @(negedge clk);
    a_blk_out_ready = 1'b0;
  endtask

  task automatic b_run(input logic [63:0] d, input logic m, output logic [63:0] res, output int lat);
    int n;
    n = 0;
    while (!b_blk_in_ready && n < 100) begin @(negedge clk); n++; end
    b_blk_in = d; b_mode = m; b_blk_in_valid = 1'b1;
    @(negedge clk);
    b_blk_in_valid = 1'b0;
    lat = 0;
    while (!b_blk_out_valid && lat < 100) begin @(negedge clk); lat++; end
    res = b_blk_out;
    b_blk_out_ready = 1'b1;
    @(negedge clk);
    b_blk_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    vecs++; if (a_key_ready !== 1'b0) begin errs++; $display("FAIL rst_key_ready got %b want 0", a_key_ready); end
    vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", a_busy); end
    vecs++; if (a_key_loaded !== 1'b0) begin errs++; $display("FAIL rst_key_loaded got %b want 0", a_key_loaded); end
    vecs++; if (a_blk_out !== 32'h0) begin errs++; $display("FAIL rst_blk_out got %h want 0", a_blk_out); end
    a_blk_in = P16; a_mode = 1'b0; a_blk_in_valid = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (a_key_ready !== 1'b1) begin errs++; $display("FAIL post_rst_key_ready got %b want 1", a_key_ready); end
    repeat (5) begin
      vecs++; if (a_blk_in_ready !== 1'b0) begin errs++; $display("FAIL idle_blk_in_ready got %b want 0", a_blk_in_ready); end
      @(negedge clk);
    end
    vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL idle_block_consumed busy got %b want 0", a_busy); end
    a_blk_in_valid = 1'b0;
    a_load_key(K16, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL key_load_timeout got %b want 1", ok); end
    vecs++; if (a_busy !== 1'b0 || a_blk_out_valid !== 1'b0) begin
      errs++; $display("FAIL idle_block_ran busy=%b valid=%b want 0 0", a_busy, a_blk_out_valid); end
    vecs++; if (a_blk_in_ready !== 1'b1) begin errs++; $display("FAIL ready_blk_in_ready got %b want 1", a_blk_in_ready); end
  endtask

  task automatic test_encrypt();
    logic [31:0] res; int lat; bit bok;
    a_run(P16, 1'b0, res, lat, bok);
    vecs++; if (res !== C16) begin errs++; $display("FAIL enc16 got %h want %h", res, C16); end
    vecs++; if (lat !== 32) begin errs++; $display("FAIL enc16_latency got %0d want 32", lat); end
    vecs++; if (bok !== 1'b1) begin errs++; $display("FAIL enc16_busy got %b want 1", bok); end
    a_drain();
    vecs++; if (a_blk_in_ready !== 1'b1) begin errs++; $display("FAIL enc16_back_to_ready got %b want 1", a_blk_in_ready); end
  endtask

  task automatic test_alternating();
    logic [31:0] res; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      logic m;
      logic [31:0] d, want;
      m = i[0];
      d = m ? C16 : P16;
      want = m ? P16 : C16;
      a_run(d, m, res, lat, bok);
      vecs++; if (res !== want) begin errs++; $display("FAIL alt16_%0d got %h want %h", i, res, want); end
      vecs++; if (lat !== 32) begin errs++; $display("FAIL alt16_lat_%0d got %0d want 32", i, lat); end
      a_drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; int lat; bit bok;
    a_run(P16, 1'b0, res, lat, bok);
    a_key = 64'h0; a_key_valid = 1'b1;
    a_blk_in = C16; a_blk_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vecs++; if (a_blk_out !== C16 || a_blk_out_valid !== 1'b1) begin
        errs++; $display("FAIL bp_hold_%0d out=%h valid=%b want %h 1", i, a_blk_out, a_blk_out_valid, C16); end
      vecs++; if (a_blk_in_ready !== 1'b0 || a_key_ready !== 1'b0) begin
        errs++; $display("FAIL bp_ready_%0d blk_in_ready=%b key_ready=%b want 0 0", i, a_blk_in_ready, a_key_ready); end
      @(negedge clk);
    end
    a_key_valid = 1'b0; a_blk_in_valid = 1'b0;
    a_drain();
    vecs++; if (a_blk_out_valid !== 1'b0 || a_blk_in_ready !== 1'b1 || a_key_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release valid=%b in_rdy=%b key_rdy=%b want 0 1 1", a_blk_out_valid, a_blk_in_ready, a_key_ready); end
    vecs++; if (a_blk_out !== C16) begin errs++; $display("FAIL bp_out_after_drain got %h want %h", a_blk_out, C16); end
    a_run(P16, 1'b0, res, lat, bok);
    vecs++; if (res !== C16) begin errs++; $display("FAIL bp_key_kept got %h want %h", res, C16); end
    a_drain();
  endtask

  task automatic test_key_priority();
    logic [31:0] res; int lat, low; bit bok;
    a_key = K16; a_key_valid = 1'b1;
    a_blk_in = P16; a_mode = 1'b0; a_blk_in_valid = 1'b1;
    #1;
    vecs++; if (a_blk_in_ready !== 1'b0) begin errs++; $display("FAIL prio_blk_in_ready got %b want 0", a_blk_in_ready); end
    @(negedge clk);
    a_key_valid = 1'b0; a_blk_in_valid = 1'b0;
    low = 0;
    while (!a_key_loaded && low < 100) begin low++; @(negedge clk); end
    vecs++; if (low !== 32) begin errs++; $display("FAIL prio_key_loaded_low got %0d want 32", low); end
    vecs++; if (a_busy !== 1'b0 || a_blk_out_valid !== 1'b0) begin
      errs++; $display("FAIL prio_block_taken busy=%b valid=%b want 0 0", a_busy, a_blk_out_valid); end
    a_run(P16, 1'b0, res, lat, bok);
    vecs++; if (res !== C16) begin errs++; $display("FAIL prio_enc got %h want %h", res, C16); end
    a_drain();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res; int lat; bit bok, ok;
    a_blk_in = P16; a_mode = 1'b0; a_blk_in_valid = 1'b1;
    @(negedge clk);
    a_blk_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (a_blk_out !== 32'h0 || a_blk_out_valid !== 1'b0) begin
      errs++; $display("FAIL midrst_out out=%h valid=%b want 0 0", a_blk_out, a_blk_out_valid); end
    vecs++; if (a_key_loaded !== 1'b0 || a_busy !== 1'b0) begin
      errs++; $display("FAIL midrst_flags key_loaded=%b busy=%b want 0 0", a_key_loaded, a_busy); end
    vecs++; if (a_key_ready !== 1'b0 || a_blk_in_ready !== 1'b0) begin
      errs++; $display("FAIL midrst_ready key=%b blk=%b want 0 0", a_key_ready, a_blk_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    a_blk_in_valid = 1'b1;
    repeat (6) @(negedge clk);
    vecs++; if (a_blk_in_ready !== 1'b0 || a_busy !== 1'b0) begin
      errs++; $display("FAIL nokey_block in_rdy=%b busy=%b want 0 0", a_blk_in_ready, a_busy); end
    a_blk_in_valid = 1'b0;
    a_load_key(K16, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL reload_timeout got %b want 1", ok); end
    a_run(P16, 1'b0, res, lat, bok);
    vecs++; if (res !== C16) begin errs++; $display("FAIL reload_enc got %h want %h", res, C16); end
    a_drain();
  endtask

  task automatic test_w32();
    logic [63:0] res; int lat, n;
    n = 0;
    while (!b_key_ready && n < 100) begin @(negedge clk); n++; end
    b_key = K32; b_key_valid = 1'b1;
    @(negedge clk);
    b_key_valid = 1'b0;
    n = 0;
    while (!b_key_loaded && n < 100) begin @(negedge clk); n++; end
    vecs++; if (b_key_loaded !== 1'b1) begin errs++; $display("FAIL w32_key_load got %b want 1", b_key_loaded); end
    b_run(P32, 1'b0, res, lat);
    vecs++; if (res !== C32) begin errs++; $display("FAIL w32_enc got %h want %h", res, C32); end
    vecs++; if (lat !== 44) begin errs++; $display("FAIL w32_latency got %0d want 44", lat); end
    b_run(C32, 1'b1, res, lat);
    vecs++; if (res !== P32) begin errs++; $display("FAIL w32_dec got %h want %h", res, P32); end
  endtask

  initial begin
    a_key_valid = 0; a_key = '0; a_blk_in_valid = 0; a_blk_in = '0; a_mode = 0; a_blk_out_ready = 0;
    b_key_valid = 0; b_key = '0; b_blk_in_valid = 0; b_blk_in = '0; b_mode = 0; b_blk_out_ready = 0;
    test_reset();
    test_encrypt();
    test_alternating();
    test_backpressure();
    test_key_priority();
    test_reset_mid_run();
    test_w32();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
